sub32_seq: RTL and testbench
============================

Name: sub32_seq

Overview:
- Multi-cycle WIDTH-bit subtractor: computes a - b with a single SLICE-bit subtract slice, processing slices LSB-first and holding the borrow in a register between cycles.
- Counterpart to the team's combinational carry-chained add datapath. It trades latency for area and is the subtract/compare unit for the sequential ALU path.
- Uses a valid/ready handshake on input and output.

Parameters:
WIDTH, 32, operand and result width; must be a multiple of SLICE
SLICE, 16, bits processed per cycle
NSLICES, WIDTH/SLICE (derived, localparam), number of slice cycles per operation

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  operands a, b presented
in_ready  output  1  unit idle and able to accept operands
a  input  WIDTH  minuend
b  input  WIDTH  subtrahend
out_valid  output  1  diff/borrow/zero hold a completed result
out_ready  input  1  consumer accepts the result
diff  output  WIDTH  (a - b) mod 2^WIDTH
borrow  output  1  1 when a < b as unsigned values
zero  output  1  1 when diff == 0

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- States: IDLE, RUN, DONE.
- Reset (rst=1 at a rising edge), from any state including mid-RUN:
  - state=IDLE; slice counter=0; borrow register=0.
  - diff=0, borrow=0, zero=0, out_valid=0.
  - in_ready is 1 in the first cycle after reset.
  - An in-flight operation is discarded with no output.
- in_ready = (state==IDLE); out_valid = (state==DONE). Both are decoded from registered state, with no combinational path from in_valid or out_ready.
- IDLE:
  - On in_valid && in_ready: latch a and b into operand registers, clear counter and borrow register, set the zero accumulator to 1, go to RUN.
  - a and b are sampled only on the accept edge. Later changes while busy are ignored.
- RUN, slice i = counter:
  - Compute {bo, d} = a[i*SLICE +: SLICE] - b[i*SLICE +: SLICE] - borrow_reg at SLICE+1 bits, unsigned.
  - bo = 1 iff the true difference is negative.
  - At the edge: write d into diff[i*SLICE +: SLICE], borrow_reg <= bo, zero_acc <= zero_acc & (d==0), counter <= counter+1.
  - After slice NSLICES-1: go to DONE, with borrow = final bo and zero = final zero_acc.
- Latency: exactly NSLICES RUN cycles. For the default configuration, out_valid is first high 3 cycles after the accept edge (1 IDLE→RUN edge + 2 slice edges).
- DONE:
  - diff, borrow and zero are stable while out_valid=1 && out_ready=0, for an unbounded stall.
  - On out_ready=1: go to IDLE. The outputs keep their values until the next operation writes them.
  - No same-cycle accept of a new operation: in_ready=0 in DONE. Throughput is one result per NSLICES+2 cycles.
- in_valid while busy is ignored, not queued; the producer must hold in_valid until in_ready.
- out_ready outside DONE has no effect.
- Width rules:
  - All arithmetic is unsigned, modulo 2^WIDTH.
  - borrow is the final borrow-out of the slice chain; a signed compare is derived externally.
  - SLICE==WIDTH (NSLICES=1) must work with a one-cycle RUN.

Test Plan:
- Reset, then a=0x00010000, b=0x00000001 -> after 3 cycles out_valid=1, diff=0x0000FFFF, borrow=0, zero=0. The slice-0 borrow must propagate into slice 1.
- a=0x00000000, b=0x00000001 -> diff=0xFFFFFFFF, borrow=1, zero=0. Also a=0xFFFFFFFF, b=0xFFFFFFFF -> diff=0, borrow=0, zero=1.
- a=0x12345678, b=0x12340000 -> diff=0x00005678, zero=0. Verifies zero is accumulated across all slices, not only the last.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while toggling in_valid, a and b -> outputs stable, in_ready=0. Release out_ready -> in_ready=1 on the next cycle, and the next operation computes correctly.
- Assert rst during the first RUN cycle of a=5, b=3 -> next cycle IDLE, out_valid=0, diff=0, in_ready=1. A following a=5, b=3 -> diff=2, borrow=0.
- Back-to-back random operands with in_valid held high and out_ready=1, 1000 ops, checked against a reference model -> each result matches, and exactly one result per accepted operand.

Source files
------------

// File: rtl/sub32_seq.sv
// sub32_seq: multi-cycle unsigned subtractor. Computes a - b with one
// SLICE-bit subtract slice per cycle, LSB slice first, carrying the borrow
// between cycles in a register. The valid/ready handshake is decoded purely
// from registered state, so neither in_ready nor out_valid depends
// combinationally on in_valid or out_ready.
module sub32_seq #(
  parameter int WIDTH = 32,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero
);

  localparam int NSLICES = WIDTH / SLICE;
  // Keep the counter at least one bit wide so NSLICES == 1 still elaborates.
  localparam int CW      = (NSLICES > 1) ? $clog2(NSLICES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] diff_q;
  logic             brw_q;      // borrow carried between slices
  logic             zacc_q;     // running "all slices zero so far"
  logic             borrow_q;   // published borrow flag
  logic             zero_q;     // published zero flag

  logic [SLICE-1:0] a_s, b_s, d_s;
  logic             bo_s;
  logic             last_s;
  logic             accept;

  assign accept = in_valid && (state_q == IDLE);
  assign last_s = (cnt_q == CW'(NSLICES - 1));

  // One slice of the subtract chain, selected by the slice counter.
  always_comb begin
    a_s = a_q[cnt_q*SLICE +: SLICE];
    b_s = b_q[cnt_q*SLICE +: SLICE];
    // Extending to SLICE+1 bits makes the top bit the borrow-out.
    {bo_s, d_s} = {1'b0, a_s} - {1'b0, b_s} - (SLICE+1)'(brw_q);
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of block ordering.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last_s) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from registered state only.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Operand capture, slice-by-slice result write-back and flag accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: a_q/b_q are deliberately not reset: they are always loaded on
      // accept before being read, so reset only the state that is observable.
      cnt_q    <= '0;
      brw_q    <= 1'b0;
      zacc_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            a_q    <= a;
            b_q    <= b;
            cnt_q  <= '0;
            brw_q  <= 1'b0;
            zacc_q <= 1'b1;
          end
        end
        RUN: begin
          diff_q[cnt_q*SLICE +: SLICE] <= d_s;
          brw_q  <= bo_s;
          zacc_q <= zacc_q & (d_s == '0);
          cnt_q  <= cnt_q + CW'(1);
          if (last_s) begin
            borrow_q <= bo_s;
            zero_q   <= zacc_q & (d_s == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign diff   = diff_q;
  assign borrow = borrow_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_sub32_seq.sv
// tb_sub32_seq: scoreboard bench for sub32_seq. Accepted operands push the
// expected result (plain unsigned arithmetic) into a queue; an independent
// monitor pops and compares each result the DUT hands over.
module tb_sub32_seq;

  localparam int W   = 32;
  localparam int LAT = 3;  // edges from accept (inclusive) to out_valid high

  typedef struct packed {
    logic [W-1:0] d;
    logic         bw;
    logic         z;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow;
  logic         zero;

  int   checks = 0;
  int   errors = 0;
  int   n_acc  = 0;
  int   n_res  = 0;
  int   n_disc = 0;
  exp_t sb[$];

  sub32_seq #(.WIDTH(32), .SLICE(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff),
    .borrow   (borrow),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    e.d  = x - y;
    e.bw = (x < y);
    e.z  = (x == y);
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Input-side observer: an accept at the coming edge queues its expectation.
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) begin
      sb.push_back(model(a, b));
      n_acc++;
    end
  end

  // Output-side monitor: every handed-over result is compared in order.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_res++;
      if (sb.size() == 0) begin
        check("unexpected result", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("diff",   diff,   e.d);
        check("borrow", borrow, e.bw);
        check("zero",   zero,   e.z);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Issue one operation from IDLE and wait until out_valid rises.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y);
    int n;
    a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, LAT);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (!in_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check("return to idle", in_ready, 1);
  endtask

  task automatic pick(output logic [W-1:0] x, output logic [W-1:0] y);
    x = $urandom;
    y = $urandom;
    case ($urandom_range(0, 5))
      0: y = x;
      1: x = '0;
      2: y = '1;
      3: y = {x[31:16], y[15:0]};
      4: y = {y[31:16], x[15:0]};
      default: ;
    endcase
  endtask

  initial begin
    exp_t          e;
    logic [W-1:0]  x, y;
    int            cnt, guard;
    logic          acc;

    in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    do_reset();
    check("reset in_ready",  in_ready,  1);
    check("reset out_valid", out_valid, 0);
    check("reset diff",      diff,      0);
    check("reset borrow",    borrow,    0);
    check("reset zero",      zero,      0);

    // Directed values: cross-slice borrow, underflow, equal, partial zero.
    run_op(32'h0001_0000, 32'h0000_0001); wait_idle();
    run_op(32'h0000_0000, 32'h0000_0001); wait_idle();
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_idle();
    run_op(32'h1234_5678, 32'h1234_0000); wait_idle();
    run_op(32'h8000_0000, 32'h7FFF_FFFF); wait_idle();

    // Backpressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    x = 32'hDEAD_BEEF; y = 32'hBEEF_DEAD;
    e = model(x, y);
    run_op(x, y);
    for (int i = 0; i < 10; i++) begin
      check("stall out_valid", out_valid, 1);
      check("stall in_ready",  in_ready,  0);
      check("stall diff",      diff,      e.d);
      check("stall borrow",    borrow,    e.bw);
      check("stall zero",      zero,      e.z);
      in_valid = 1'(($urandom_range(0, 1)));
      a = $urandom; b = $urandom;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("in_ready after release", in_ready, 1);
    run_op(32'h0000_0100, 32'h0000_0200); wait_idle();

    // Reset during the first RUN cycle discards the operation.
    a = 32'd5; b = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    n_disc++;
    check("mid-run reset in_ready",  in_ready,  1);
    check("mid-run reset out_valid", out_valid, 0);
    check("mid-run reset diff",      diff,      0);
    check("mid-run reset borrow",    borrow,    0);
    run_op(32'd5, 32'd3); wait_idle();

    // Back-to-back random operations with in_valid held high.
    out_ready = 1'b1;
    pick(x, y);
    a = x; b = y; in_valid = 1'b1;
    cnt = 0; guard = 0;
    while (cnt < 1000 && guard < 20000) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      guard++;
      if (acc) begin
        cnt++;
        pick(x, y);
        a = x; b = y;
      end
    end
    in_valid = 1'b0;
    check("random ops accepted", cnt, 1000);
    guard = 0;
    while (sb.size() != 0 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    @(posedge clk); #1;
    check("scoreboard drained", sb.size(), 0);
    check("one result per op", n_res, n_acc - n_disc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
